// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the 5-stage CPU.
// Decodes opcode/aluop in D into an 18-bit control bundle, carries it through
// the D/X, X/M and M/W registers, and generates stall, flush and the mult/div
// start/wait handshake with a watchdog.
// Optional feature macro: PIPE_CTRL_SETX_BEX_EN adds setx (21) and bex (22).
module pipe_ctrl #(
  parameter int OPW           = 5,
  parameter int MD_MAX_CYCLES = 34
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] d_opcode,
  input  logic [OPW-1:0] d_aluop,
  input  logic           d_valid,
  input  logic           br_taken,
  input  logic           md_ready,
  output logic [17:0]    ctrl_x,
  output logic [17:0]    ctrl_m,
  output logic [17:0]    ctrl_w,
  output logic           stall,
  output logic           flush,
  output logic           md_start,
  output logic           md_timeout
);

  // Bundle layout, MSB first, so that the packed struct maps onto bits [17:0].
  typedef struct packed {
    logic       valid;     // [17]
    logic       is_md;     // [16]
    logic [1:0] pc_sel;    // [15:14] 00 PC+1, 01 PC+1+imm, 10 target, 11 rd
    logic       blt;       // [13]
    logic       bne;       // [12]
    logic [1:0] wb_sel;    // [11:10] 00 ALU, 01 DMEM, 10 PC+1
    logic       dmwe;      // [9]
    logic [4:0] aluop;     // [8:4]
    logic       alu_sei;   // [3]
    logic [1:0] dest_sel;  // [2:1] 00 rd, 01 r31, 10 r30
    logic       rwe;       // [0]
  } ctrl_t;

  typedef enum logic {
    S_IDLE,
    S_MD_WAIT
  } state_t;

  localparam logic [OPW-1:0] OP_ALU  = OPW'(0);
  localparam logic [OPW-1:0] OP_J    = OPW'(1);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(3);
  localparam logic [OPW-1:0] OP_JR   = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(6);
  localparam logic [OPW-1:0] OP_SW   = OPW'(7);
  localparam logic [OPW-1:0] OP_LW   = OPW'(8);
`ifdef PIPE_CTRL_SETX_BEX_EN
  localparam logic [OPW-1:0] OP_SETX = OPW'(21);
  localparam logic [OPW-1:0] OP_BEX  = OPW'(22);
`endif

  // Counter only has to reach MD_MAX_CYCLES-1.
  localparam int CW = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX_CYCLES - 1);

  ctrl_t        dec;
  ctrl_t        x_q, x_d, m_q, m_d, w_q, w_d;
  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         jump_flush;

`ifdef PIPE_CTRL_SETX_BEX_EN
  // bex shares pc_sel=10 with j/jal but is conditional, so X tracks it apart.
  logic dec_bex;
  logic x_bex_q, x_bex_d;
`endif

  // Decode the D-stage fields into a control bundle.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec = '0;
`ifdef PIPE_CTRL_SETX_BEX_EN
    dec_bex = 1'b0;
`endif
    // An empty decode slot yields a pure bubble so no datapath enable leaks.
    if (d_valid) begin
      dec.valid = 1'b1;
      case (d_opcode)
        OP_ALU: begin
          dec.rwe   = 1'b1;
          dec.aluop = 5'(d_aluop);
          dec.is_md = (d_aluop == OPW'(6)) || (d_aluop == OPW'(7));
        end
        OP_J: dec.pc_sel = 2'b10;
        OP_BNE: begin
          dec.bne    = 1'b1;
          dec.aluop  = 5'd1;
          dec.pc_sel = 2'b01;
        end
        OP_JAL: begin
          dec.rwe      = 1'b1;
          dec.dest_sel = 2'b01;
          dec.wb_sel   = 2'b10;
          dec.pc_sel   = 2'b10;
        end
        OP_JR: dec.pc_sel = 2'b11;
        OP_ADDI: begin
          dec.rwe     = 1'b1;
          dec.alu_sei = 1'b1;
        end
        OP_BLT: begin
          dec.blt    = 1'b1;
          dec.aluop  = 5'd1;
          dec.pc_sel = 2'b01;
        end
        OP_SW: begin
          dec.alu_sei = 1'b1;
          dec.dmwe    = 1'b1;
        end
        OP_LW: begin
          dec.rwe     = 1'b1;
          dec.alu_sei = 1'b1;
          dec.wb_sel  = 2'b01;
        end
`ifdef PIPE_CTRL_SETX_BEX_EN
        OP_SETX: begin
          dec.rwe      = 1'b1;
          dec.dest_sel = 2'b10;
        end
        OP_BEX: begin
          dec.pc_sel = 2'b10;
          dec_bex    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Redirect condition for the instruction currently in X.
  always_comb begin
`ifdef PIPE_CTRL_SETX_BEX_EN
    jump_flush = ((x_q.pc_sel == 2'b10) && !x_bex_q) ||
                 (x_q.pc_sel == 2'b11) ||
                 (((x_q.pc_sel == 2'b01) || x_bex_q) && br_taken);
`else
    jump_flush = x_q.pc_sel[1] || ((x_q.pc_sel == 2'b01) && br_taken);
`endif
  end

  // Mult/div stall FSM: launch, wait for md_ready, or give up on the watchdog.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (x_q.valid && x_q.is_md) begin
          md_start = 1'b1;
          stall    = 1'b1;
          cnt_d    = '0;
          state_d  = S_MD_WAIT;
        end
      end
      S_MD_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (md_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          md_timeout = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall has priority: flush is masked whenever the pipe is frozen.
  always_comb flush = x_q.valid && !stall && jump_flush;

  // Next-state of the D/X, X/M and M/W bundle registers.
  always_comb begin
    x_d = dec;
    m_d = x_q;
    w_d = m_q;
`ifdef PIPE_CTRL_SETX_BEX_EN
    x_bex_d = dec_bex;
`endif
    if (stall) begin
      x_d = x_q;
      m_d = '0;
`ifdef PIPE_CTRL_SETX_BEX_EN
      x_bex_d = x_bex_q;
`endif
    end else if (flush) begin
      x_d = '0;
`ifdef PIPE_CTRL_SETX_BEX_EN
      x_bex_d = 1'b0;
`endif
    end
  end

  // State and pipeline registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
`ifdef PIPE_CTRL_SETX_BEX_EN
      x_bex_q <= 1'b0;
`endif
    end else begin
      x_q     <= x_d;
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PIPE_CTRL_SETX_BEX_EN
      x_bex_q <= x_bex_d;
`endif
    end
  end

  assign ctrl_x = x_q;
  assign ctrl_m = m_q;
  assign ctrl_w = w_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: decode map, pipeline delay, mult/div
// stall handshake, watchdog timeout, flush, back-to-back mults, reset.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  d_opcode;
  logic [4:0]  d_aluop;
  logic        d_valid;
  logic        br_taken;
  logic        md_ready;
  logic [17:0] ctrl_x, ctrl_m, ctrl_w;
  logic        stall, flush, md_start, md_timeout;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.OPW(5), .MD_MAX_CYCLES(34)) dut (
    .clock      (clock),
    .reset      (reset),
    .d_opcode   (d_opcode),
    .d_aluop    (d_aluop),
    .d_valid    (d_valid),
    .br_taken   (br_taken),
    .md_ready   (md_ready),
    .ctrl_x     (ctrl_x),
    .ctrl_m     (ctrl_m),
    .ctrl_w     (ctrl_w),
    .stall      (stall),
    .flush      (flush),
    .md_start   (md_start),
    .md_timeout (md_timeout)
  );

  always #5 clock = ~clock;

  // Build an expected valid bundle from its fields.
  function automatic logic [17:0] bnd(input logic rwe, input logic [1:0] dest,
                                      input logic sei, input logic [4:0] aluop,
                                      input logic dmwe, input logic [1:0] wb,
                                      input logic bne, input logic blt,
                                      input logic [1:0] pc, input logic md);
    return {1'b1, md, pc, blt, bne, wb, dmwe, aluop, sei, dest, rwe};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] alu, input logic v);
    d_opcode = op;
    d_aluop  = alu;
    d_valid  = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; br_taken = 1'b0; md_ready = 1'b0;
    drive(5'd0, 5'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    total++; if (ctrl_x !== 18'h0 || ctrl_m !== 18'h0 || ctrl_w !== 18'h0) begin
      bad++; $display("FAIL reset_bundles: got x=%h m=%h w=%h want 0", ctrl_x, ctrl_m, ctrl_w); end
    total++; if ({stall, flush, md_start, md_timeout} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {stall, flush, md_start, md_timeout}); end
  endtask

  task automatic test_addi();
    logic [17:0] e;
    e = bnd(1, 2'b00, 1, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0);
    drive(5'd5, 5'd3, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0);
    total++; if (ctrl_x !== e) begin bad++; $display("FAIL addi_x: got %h want %h", ctrl_x, e); end
    tick();
    total++; if (ctrl_m !== e || ctrl_x !== 18'h0) begin
      bad++; $display("FAIL addi_m: got m=%h x=%h want m=%h x=0", ctrl_m, ctrl_x, e); end
    tick();
    total++; if (ctrl_w !== e) begin bad++; $display("FAIL addi_w: got %h want %h", ctrl_w, e); end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  alu;
    logic [17:0] exp;
    logic        exp_flush;
    string       name;
  } vec_t;

  task automatic test_decode();
    vec_t v[$];
    v.push_back('{5'd0, 5'd2, bnd(1, 2'b00, 0, 5'd2, 0, 2'b00, 0, 0, 2'b00, 0), 1'b0, "alu_add"});
    v.push_back('{5'd1, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b10, 0), 1'b1, "j"});
    v.push_back('{5'd2, 5'd9, bnd(0, 2'b00, 0, 5'd1, 0, 2'b00, 1, 0, 2'b01, 0), 1'b0, "bne_nt"});
    v.push_back('{5'd3, 5'd9, bnd(1, 2'b01, 0, 5'd0, 0, 2'b10, 0, 0, 2'b10, 0), 1'b1, "jal"});
    v.push_back('{5'd4, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b11, 0), 1'b1, "jr"});
    v.push_back('{5'd6, 5'd9, bnd(0, 2'b00, 0, 5'd1, 0, 2'b00, 0, 1, 2'b01, 0), 1'b0, "blt_nt"});
    v.push_back('{5'd7, 5'd9, bnd(0, 2'b00, 1, 5'd0, 1, 2'b00, 0, 0, 2'b00, 0), 1'b0, "sw"});
    v.push_back('{5'd8, 5'd9, bnd(1, 2'b00, 1, 5'd0, 0, 2'b01, 0, 0, 2'b00, 0), 1'b0, "lw"});
    v.push_back('{5'd9, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0), 1'b0, "op9_nop"});
`ifdef PIPE_CTRL_SETX_BEX_EN
    v.push_back('{5'd21, 5'd9, bnd(1, 2'b10, 0, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0), 1'b0, "setx"});
    v.push_back('{5'd22, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b10, 0), 1'b0, "bex_nt"});
`else
    v.push_back('{5'd21, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0), 1'b0, "op21_nop"});
    v.push_back('{5'd22, 5'd9, bnd(0, 2'b00, 0, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0), 1'b0, "op22_nop"});
`endif
    foreach (v[i]) begin
      drive(v[i].op, v[i].alu, 1'b1);
      br_taken = 1'b0;
      tick();
      drive(5'd0, 5'd0, 1'b0);
      #1;
      total++; if (ctrl_x !== v[i].exp) begin
        bad++; $display("FAIL dec_%s: got %h want %h", v[i].name, ctrl_x, v[i].exp); end
      total++; if (flush !== v[i].exp_flush) begin
        bad++; $display("FAIL flush_%s: got %b want %b", v[i].name, flush, v[i].exp_flush); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [17:0] e_bne, e_blt, e_addi;
    e_bne  = bnd(0, 2'b00, 0, 5'd1, 0, 2'b00, 1, 0, 2'b01, 0);
    e_blt  = bnd(0, 2'b00, 0, 5'd1, 0, 2'b00, 0, 1, 2'b01, 0);
    e_addi = bnd(1, 2'b00, 1, 5'd0, 0, 2'b00, 0, 0, 2'b00, 0);
    // bne taken: the following addi in decode is squashed.
    drive(5'd2, 5'd0, 1'b1);
    tick();
    drive(5'd5, 5'd0, 1'b1); br_taken = 1'b1;
    #1;
    total++; if (ctrl_x !== e_bne || flush !== 1'b1) begin
      bad++; $display("FAIL bne_taken: got x=%h flush=%b want x=%h flush=1", ctrl_x, flush, e_bne); end
    tick();
    br_taken = 1'b0; drive(5'd0, 5'd0, 1'b0);
    total++; if (ctrl_x !== 18'h0 || ctrl_m !== e_bne) begin
      bad++; $display("FAIL bne_bubble: got x=%h m=%h want x=0 m=%h", ctrl_x, ctrl_m, e_bne); end
    tick();
    // bne not taken: addi proceeds.
    drive(5'd2, 5'd0, 1'b1);
    tick();
    drive(5'd5, 5'd0, 1'b1); br_taken = 1'b0;
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL bne_nt_flush: got %b want 0", flush); end
    tick();
    drive(5'd0, 5'd0, 1'b0);
    total++; if (ctrl_x !== e_addi) begin bad++; $display("FAIL bne_nt_next: got %h want %h", ctrl_x, e_addi); end
    tick();
    // blt taken.
    drive(5'd6, 5'd0, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0); br_taken = 1'b1;
    #1;
    total++; if (ctrl_x !== e_blt || flush !== 1'b1) begin
      bad++; $display("FAIL blt_taken: got x=%h flush=%b want x=%h flush=1", ctrl_x, flush, e_blt); end
    tick();
    br_taken = 1'b0;
`ifdef PIPE_CTRL_SETX_BEX_EN
    // bex taken redirects; the not-taken case is in the decode table.
    drive(5'd22, 5'd0, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0); br_taken = 1'b1;
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL bex_taken: got %b want 1", flush); end
    tick();
    br_taken = 1'b0;
`endif
    tick();
  endtask

  task automatic test_mult();
    logic [17:0] e;
    e = bnd(1, 2'b00, 0, 5'd6, 0, 2'b00, 0, 0, 2'b00, 1);
    drive(5'd0, 5'd6, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0);
    total++; if (ctrl_x !== e || md_start !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL mult_launch: got x=%h start=%b stall=%b want x=%h 1 1", ctrl_x, md_start, stall, e); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (stall !== 1'b1 || md_start !== 1'b0 || ctrl_m !== 18'h0 || ctrl_x !== e) begin
        bad++; $display("FAIL mult_wait%0d: got stall=%b start=%b m=%h x=%h want 1 0 0 %h",
                        k, stall, md_start, ctrl_m, ctrl_x, e); end
    end
    tick();
    md_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || ctrl_m !== 18'h0) begin
      bad++; $display("FAIL mult_ready: got stall=%b m=%h want 0 0", stall, ctrl_m); end
    tick();
    md_ready = 1'b0;
    #1;
    total++; if (ctrl_m !== e || ctrl_x !== 18'h0 || md_start !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL mult_adv: got m=%h x=%h start=%b stall=%b want %h 0 0 0",
                      ctrl_m, ctrl_x, md_start, stall, e); end
    tick();
    total++; if (ctrl_w !== e) begin bad++; $display("FAIL mult_w: got %h want %h", ctrl_w, e); end
  endtask

  task automatic test_timeout();
    logic [17:0] e;
    e = bnd(1, 2'b00, 0, 5'd7, 0, 2'b00, 0, 0, 2'b00, 1);
    md_ready = 1'b0;
    drive(5'd0, 5'd7, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL to_launch: got %b want 1", md_start); end
    for (int i = 1; i <= 33; i++) begin
      tick();
      total++; if (stall !== 1'b1 || md_timeout !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d: got stall=%b timeout=%b want 1 0", i, stall, md_timeout); end
    end
    tick();
    total++; if (md_timeout !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL to_pulse: got timeout=%b stall=%b want 1 0", md_timeout, stall); end
    tick();
    total++; if (md_timeout !== 1'b0 || md_start !== 1'b0 || ctrl_m !== e) begin
      bad++; $display("FAIL to_after: got timeout=%b start=%b m=%h want 0 0 %h", md_timeout, md_start, ctrl_m, e); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e1, e2;
    e1 = bnd(1, 2'b00, 0, 5'd6, 0, 2'b00, 0, 0, 2'b00, 1);
    e2 = bnd(1, 2'b00, 0, 5'd7, 0, 2'b00, 0, 0, 2'b00, 1);
    drive(5'd0, 5'd6, 1'b1);
    tick();
    drive(5'd0, 5'd7, 1'b1);
    #1;
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL b2b_start1: got %b want 1", md_start); end
    tick();
    total++; if (stall !== 1'b1 || md_start !== 1'b0 || ctrl_x !== e1) begin
      bad++; $display("FAIL b2b_hold: got stall=%b start=%b x=%h want 1 0 %h", stall, md_start, ctrl_x, e1); end
    tick();
    md_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_release: got %b want 0", stall); end
    tick();
    md_ready = 1'b0; drive(5'd0, 5'd0, 1'b0);
    #1;
    total++; if (ctrl_x !== e2 || md_start !== 1'b1 || ctrl_m !== e1) begin
      bad++; $display("FAIL b2b_start2: got x=%h start=%b m=%h want %h 1 %h", ctrl_x, md_start, ctrl_m, e2, e1); end
    tick();
    md_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || md_start !== 1'b0) begin
      bad++; $display("FAIL b2b_done: got stall=%b start=%b want 0 0", stall, md_start); end
    tick();
    md_ready = 1'b0;
    #1;
    total++; if (ctrl_m !== e2 || md_start !== 1'b0) begin
      bad++; $display("FAIL b2b_adv: got m=%h start=%b want %h 0", ctrl_m, md_start, e2); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd0, 5'd6, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b0);
    repeat (2) tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rmw_pre: got stall=%b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || md_start !== 1'b0 || ctrl_x !== 18'h0 || ctrl_m !== 18'h0 || ctrl_w !== 18'h0) begin
      bad++; $display("FAIL rmw_post: got stall=%b start=%b x=%h m=%h w=%h want all 0",
                      stall, md_start, ctrl_x, ctrl_m, ctrl_w); end
    tick();
    total++; if (stall !== 1'b0 || md_start !== 1'b0 || md_timeout !== 1'b0) begin
      bad++; $display("FAIL rmw_idle: got stall=%b start=%b timeout=%b want 0 0 0", stall, md_start, md_timeout); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_branch();
    test_mult();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 5-stage CPU. It decodes `opcode`/`aluop` in the decode stage into a packed control bundle and carries that bundle through the D/X, X/M and M/W pipeline registers. It also generates stall, flush and the mult/div start/wait handshake. It sits between the decode-stage instruction fields and every datapath mux, and replaces per-stage re-decoding.

## Interface
Parameters:
- `OPW`, 5: opcode and ALU-op field width.
- `MD_MAX_CYCLES`, 34: watchdog limit, in cycles, for waiting on `md_ready`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `d_opcode` in OPW: opcode of the instruction in decode.
- `d_aluop` in OPW: ALU-op field of the instruction in decode.
- `d_valid` in 1: decode slot holds a real instruction.
- `br_taken` in 1: branch in X resolved taken (comparison is done externally).
- `md_ready` in 1: mult/div result valid.
- `ctrl_x`, `ctrl_m`, `ctrl_w` out 18: control bundle for X, M and W.
- `stall` out 1: freeze PC, F/D and D/X.
- `flush` out 1: squash F/D and the decode slot.
- `md_start` out 1: one-cycle mult/div launch.
- `md_timeout` out 1: one-cycle watchdog error pulse.

Bundle layout:
- [0] rwe
- [2:1] dest_sel: 00 = rd, 01 = r31, 10 = r30
- [3] alu_sei
- [8:4] aluop
- [9] dmwe
- [11:10] wb_sel: 00 = ALU, 01 = DMEM, 10 = PC+1
- [12] bne
- [13] blt
- [15:14] pc_sel: 00 = PC+1, 01 = PC+1+imm, 10 = target, 11 = rd
- [16] is_md
- [17] valid

## Operation
Decode (combinational, in the D stage). Opcode map: 0 ALU, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw. All other opcodes decode to an all-zero bundle with valid=`d_valid`.
- rwe = ALU | lw | jal | addi.
- dest_sel = 01 on jal; otherwise 00.
- alu_sei = addi | lw | sw.
- aluop = `d_aluop` for ALU ops, 00000 for addi/lw/sw, 00001 (sub) for bne/blt.
- dmwe = sw.
- wb_sel = 01 on lw, 10 on jal.
- pc_sel = 01 on bne/blt, 10 on j/jal, 11 on jr.
- is_md = ALU & (aluop == 6 | aluop == 7).

Pipeline:
- ctrl_x ← decoded bundle.
- ctrl_m ← ctrl_x.
- ctrl_w ← ctrl_m.

Stall FSM, states IDLE and MD_WAIT:
- IDLE and ctrl_x.valid & ctrl_x.is_md: `md_start`=1, `stall`=1, next state MD_WAIT, counter cleared.
- MD_WAIT: `stall` = !md_ready. Counter increments each cycle.
- MD_WAIT and `md_ready`: next state IDLE. The instruction in X advances that cycle.
- MD_WAIT and counter reaches MD_MAX_CYCLES−1 without `md_ready`: `md_timeout` pulses, next state IDLE, `stall` drops.
- While `stall`=1: ctrl_x holds, ctrl_m loads a bubble (all zero), ctrl_w advances.

Flush:
- `flush` = ctrl_x.valid & !stall & (pc_sel[1] | (pc_sel == 01 & br_taken)).
- On `flush`, ctrl_x loads a bubble instead of the decode bundle.

Simultaneous events:
- stall and flush: stall wins, and `flush` is forced to 0. This cannot occur legally, because is_md and a branch cannot both be in X.

## Timing
- Decode to ctrl_x: 1 cycle. ctrl_m: 2 cycles. ctrl_w: 3 cycles.
- `stall`, `flush` and `md_start` are combinational from current state and ctrl_x.
- `md_start` is exactly one cycle per mult/div, and never reasserts for the same held instruction.
- Reset: ctrl_x, ctrl_m and ctrl_w are all 0; state IDLE; counter 0. As a result, `stall`, `flush`, `md_start` and `md_timeout` are all 0.
- Reset during MD_WAIT: next cycle is IDLE with `stall`=0, and the pipeline is empty.
- Back-to-back mult: the second reaches X the cycle after the first leaves, and gets its own `md_start`.

## Configuration
- `PIPE_CTRL_SETX_BEX_EN` defined:
  - Opcode 21 (setx) decodes to rwe=1, dest_sel=10, wb_sel=00, aluop=0.
  - Opcode 22 (bex) decodes to pc_sel=10 and contributes to `flush` when `br_taken` is 1 (external check: r30≠0).
- Not defined: opcodes 21 and 22 decode as valid NOPs (all-zero fields apart from valid).

## Test plan
- Reset, then `d_valid`=1, opcode 5 (addi): after 1 cycle, ctrl_x = rwe=1, alu_sei=1, aluop=0, valid=1. The same bundle appears on ctrl_w 2 cycles later.
- ALU opcode 0, aluop 6, `md_ready` high 5 cycles after `md_start`: `md_start` for 1 cycle, `stall`=1 for 5 cycles, ctrl_m is a bubble for 5 cycles, then the mult proceeds to ctrl_m.
- Mult with `md_ready` never asserted, MD_MAX_CYCLES=34: `md_timeout` pulses in the 34th MD_WAIT cycle, and `stall` drops in that same cycle.
- bne in X with `br_taken`=1: `flush`=1 and the next ctrl_x is a bubble. With `br_taken`=0: `flush`=0.
- jr in X: pc_sel=11 and `flush`=1. jal in X: dest_sel=01, wb_sel=10, rwe=1.
- Opcode 21 with the macro defined: dest_sel=10, rwe=1. Opcode 21 without the macro: rwe=0, valid=1.
